// File: rtl/iccm_port_arbiter.sv
// ICCM port arbiter: shares one DFFRAM between the core port and the loader.
// Optional ICCM_ARB_PERF_CNT_EN adds perf_conflict_o / perf_forced_o.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   core_*               core req/gnt port, 1-cycle read response
//   prog_*               loader write stream (req held until gnt)
//   ram_*                DFFRAM EN/WE/A/Di/Do
//   perf_*_o             saturating counters (macro only)
module iccm_port_arbiter #(
  parameter int unsigned AW       = 14,
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic              core_we_i,
  input  logic [AW-1:0]     core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [31:0]       core_wmask_i,
  output logic [31:0]       core_rdata_o,
  output logic              core_rvalid_o,
  output logic [1:0]        core_rerror_o,
  input  logic              prog_we_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [31:0]       prog_wdata_i,
  output logic              prog_gnt_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  input  logic [31:0]       ram_do_i
`ifdef ICCM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_conflict_o,
  output logic [15:0]       perf_forced_o
`endif
);

  localparam bit        FORCE_EN = (MAX_WAIT != 0);
  localparam logic [7:0] LIMIT   = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt;
  logic       force_core;
  logic       core_sel;
  logic       prog_sel;
  logic       core_oor;
  logic       prog_oor;
  logic       rvalid_q;
  logic       rerr_q;
  logic [3:0] byte_we;

  // Any address bit above the RAM window marks the access out of range.
  assign core_oor = |(core_addr_i >> RAM_AW);
  assign prog_oor = |(prog_addr_i >> RAM_AW);

  assign core_sel = rst_ni & core_req_i & (~prog_we_i | force_core);
  assign prog_sel = rst_ni & prog_we_i & ~core_sel;

  assign core_gnt_o = core_sel;
  assign prog_gnt_o = prog_sel;

  always_comb begin
    byte_we = '0;
    for (int i = 0; i < 4; i++) begin
      byte_we[i] = |core_wmask_i[8*i +: 8];
    end
  end

  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = 4'h0;
    ram_a_o  = '0;
    ram_di_o = '0;
    unique case (1'b1)
      prog_sel: begin
        ram_en_o = ~prog_oor;
        ram_we_o = prog_oor ? 4'h0 : 4'hF;
        ram_a_o  = prog_addr_i[RAM_AW-1:0];
        ram_di_o = prog_wdata_i;
      end
      core_sel: begin
        ram_en_o = ~core_oor;
        ram_we_o = (core_we_i & ~core_oor) ? byte_we : 4'h0;
        ram_a_o  = core_addr_i[RAM_AW-1:0];
        ram_di_o = core_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      wait_cnt   <= '0;
      force_core <= 1'b0;
    end else begin
      rvalid_q <= core_sel & ~core_we_i;
      rerr_q   <= core_sel & ~core_we_i & core_oor;
      if (core_sel || !core_req_i) begin
        wait_cnt <= '0;
      end else if (prog_we_i && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // Armed on the MAX_WAIT-th denied cycle, held until the core wins.
      if (core_sel) begin
        force_core <= 1'b0;
      end else if (FORCE_EN && core_req_i && prog_we_i
                   && wait_cnt == LIMIT) begin
        force_core <= 1'b1;
      end
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rerror_o = {1'b0, rerr_q};
  assign core_rdata_o  = (rvalid_q & ~rerr_q) ? ram_do_i : 32'h0;

`ifdef ICCM_ARB_PERF_CNT_EN
  logic [15:0] conflict_q;
  logic [15:0] forced_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (core_req_i && prog_we_i && conflict_q != 16'hFFFF) begin
        conflict_q <= conflict_q + 16'd1;
      end
      if (core_sel && force_core && forced_q != 16'hFFFF) begin
        forced_q <= forced_q + 16'd1;
      end
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_forced_o   = forced_q;
`endif

endmodule
